// File: rtl/mfi_trace_buffer.sv
// Trace FIFO for retired-instruction records; head is registered-array output, 1-cycle write-to-read.
// Drops and flags overflow when full without a pop; optional PC continuity check under MFI_TRACE_PC_CHECK_EN.
module mfi_trace_buffer #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     mfi_valid,
   input  logic                     mfi_trap,
   input  logic [31:0]              mfi_inst,
   input  logic [31:0]              mfi_pc_rdata,
   input  logic [31:0]              mfi_pc_wdata,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_inst,
   output logic [31:0]              out_pc,
   output logic                     out_trap,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [31:0]              retire_count,
   output logic                     pc_break
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   typedef struct packed {
      logic        trap;
      logic [31:0] pc;
      logic [31:0] inst;
   } rec_t;

   rec_t          mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          overflow_q, overflow_d;
   logic [31:0]   retire_q, retire_d;
   logic          full, push, pop;
   rec_t          head;

   always_comb begin
      full       = (level_q == FULL_LVL);
      pop        = (level_q != '0) && out_ready;
      // A pop on the same edge frees the slot, so a full FIFO can still accept.
      push       = mfi_valid && (!full || pop);
      wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      level_d    = level_q;
      if (push && !pop)      level_d = level_q + 1'b1;
      else if (pop && !push) level_d = level_q - 1'b1;
      overflow_d = overflow_q || (mfi_valid && full && !pop);
      retire_d   = mfi_valid ? retire_q + 32'd1 : retire_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         retire_q   <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         retire_q   <= retire_d;
      end
   end

   // Storage is never reset; contents are only observed while level is non-zero.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= '{trap: mfi_trap, pc: mfi_pc_rdata, inst: mfi_inst};
   end

   assign head         = mem_q[rd_ptr_q];
   assign out_valid    = (level_q != '0);
   assign out_inst     = head.inst;
   assign out_pc       = head.pc;
   assign out_trap     = head.trap;
   assign level        = level_q;
   assign overflow     = overflow_q;
   assign retire_count = retire_q;

`ifdef MFI_TRACE_PC_CHECK_EN
   logic [31:0] prev_pc_q, prev_pc_d;
   logic        have_prev_q, have_prev_d;
   logic        pc_break_q, pc_break_d;

   always_comb begin
      prev_pc_d   = prev_pc_q;
      have_prev_d = have_prev_q;
      pc_break_d  = pc_break_q;
      if (mfi_valid) begin
         prev_pc_d   = mfi_pc_wdata;
         have_prev_d = 1'b1;
         if (have_prev_q && (mfi_pc_rdata != prev_pc_q)) pc_break_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_pc_q   <= '0;
         have_prev_q <= 1'b0;
         pc_break_q  <= 1'b0;
      end else begin
         prev_pc_q   <= prev_pc_d;
         have_prev_q <= have_prev_d;
         pc_break_q  <= pc_break_d;
      end
   end

   assign pc_break = pc_break_q;
`else
   logic unused_pc_wdata;
   assign unused_pc_wdata = ^mfi_pc_wdata;
   assign pc_break        = 1'b0;
`endif

endmodule

// File: tb/tb_mfi_trace_buffer.sv
// Directed bench for mfi_trace_buffer (DEPTH=8); pc_break expectation follows MFI_TRACE_PC_CHECK_EN.
module tb_mfi_trace_buffer;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        mfi_valid, mfi_trap;
   logic [31:0] mfi_inst, mfi_pc_rdata, mfi_pc_wdata;
   logic        out_valid, out_ready, out_trap;
   logic [31:0] out_inst, out_pc;
   logic [3:0]  level;
   logic        overflow, pc_break;
   logic [31:0] retire_count;

   int total = 0;
   int bad   = 0;

`ifdef MFI_TRACE_PC_CHECK_EN
   localparam logic [31:0] EXP_BREAK = 32'd1;
`else
   localparam logic [31:0] EXP_BREAK = 32'd0;
`endif

   mfi_trace_buffer #(.DEPTH(8)) dut (
      .clk(clk), .reset_n(reset_n),
      .mfi_valid(mfi_valid), .mfi_trap(mfi_trap), .mfi_inst(mfi_inst),
      .mfi_pc_rdata(mfi_pc_rdata), .mfi_pc_wdata(mfi_pc_wdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_inst(out_inst), .out_pc(out_pc), .out_trap(out_trap),
      .level(level), .overflow(overflow), .retire_count(retire_count),
      .pc_break(pc_break)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return {16'hC0DE, pc[15:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rec(input logic [31:0] pc, input logic trap);
      mfi_valid    = 1'b1;
      mfi_trap     = trap;
      mfi_pc_rdata = pc;
      mfi_pc_wdata = pc + 32'd4;
      mfi_inst     = inst_of(pc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset with retirements presented: they must be ignored.
      reset_n = 1'b0; out_ready = 1'b0;
      set_rec(32'h0000_0F00, 1'b0);
      tick(); tick();
      chk("rst_level", 32'(level), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_retire", retire_count, 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_pc_break", 32'(pc_break), 0);
      mfi_valid = 1'b0;
      reset_n   = 1'b1;

      // Three retirements, no pops; first record visible after one edge.
      set_rec(32'h0, 1'b0);
      tick();
      chk("lat_out_valid", 32'(out_valid), 1);
      chk("lat_level", 32'(level), 1);
      chk("lat_out_pc", out_pc, 32'h0);
      for (int i = 1; i < 3; i++) begin
         set_rec(32'(i * 4), 1'b0);
         tick();
      end
      chk("three_level", 32'(level), 3);
      chk("three_out_pc", out_pc, 32'h0);
      chk("three_out_inst", out_inst, inst_of(32'h0));
      chk("three_retire", retire_count, 3);

      // Idle cycle with out_ready=0: head holds.
      mfi_valid = 1'b0;
      tick();
      chk("hold_out_pc", out_pc, 32'h0);
      chk("hold_level", 32'(level), 3);

      // Six more retirements (nine total): last one dropped.
      for (int i = 3; i < 9; i++) begin
         set_rec(32'(i * 4), (i == 5));
         tick();
      end
      mfi_valid = 1'b0;
      chk("ovf_level", 32'(level), 8);
      chk("ovf_flag", 32'(overflow), 1);
      chk("ovf_retire", retire_count, 9);
      chk("cont_pc_break", 32'(pc_break), 0);

      // Drain: the first eight pcs in order.
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("drain_pc%0d", i), out_pc, 32'(i * 4));
         chk($sformatf("drain_trap%0d", i), 32'(out_trap), 32'(i == 5));
         tick();
      end
      chk("drained_level", 32'(level), 0);
      chk("drained_out_valid", 32'(out_valid), 0);
      chk("drained_overflow_sticky", 32'(overflow), 1);

      // Continuous push and pop from empty.
      chk("stream_pre_out_valid", 32'(out_valid), 0);
      for (int k = 0; k < 6; k++) begin
         set_rec(32'h100 + 32'(k * 4), 1'b0);
         tick();
         chk($sformatf("stream_valid%0d", k), 32'(out_valid), 1);
         chk($sformatf("stream_pc%0d", k), out_pc, 32'h100 + 32'(k * 4));
         chk($sformatf("stream_level%0d", k), 32'(level), 1);
      end
      mfi_valid = 1'b0;
      tick();
      chk("stream_end_level", 32'(level), 0);

      // Fill to 5 then assert reset mid-cycle.
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         set_rec(32'h300 + 32'(k * 4), 1'b0);
         tick();
      end
      mfi_valid = 1'b0;
      chk("pre_rst_level", 32'(level), 5);
      #3 reset_n = 1'b0;
      #1;
      chk("async_rst_level", 32'(level), 0);
      chk("async_rst_out_valid", 32'(out_valid), 0);
      chk("async_rst_retire", retire_count, 0);
      chk("async_rst_overflow", 32'(overflow), 0);
      tick();
      reset_n = 1'b1;

      // Full FIFO with simultaneous push and pop.
      for (int k = 0; k < 8; k++) begin
         set_rec(32'h200 + 32'(k * 4), 1'b0);
         tick();
      end
      chk("full_level", 32'(level), 8);
      chk("full_overflow", 32'(overflow), 0);
      set_rec(32'h220, 1'b0);
      out_ready = 1'b1;
      tick();
      mfi_valid = 1'b0;
      chk("fullpp_level", 32'(level), 8);
      chk("fullpp_overflow", 32'(overflow), 0);
      chk("fullpp_retire", retire_count, 9);
      for (int k = 1; k < 9; k++) begin
         chk($sformatf("fullpp_drain%0d", k), out_pc, 32'h200 + 32'(k * 4));
         tick();
      end
      chk("fullpp_end_level", 32'(level), 0);

      // PC continuity: wdata 0x8 then rdata 0xC.
      reset_n = 1'b0;
      tick();
      reset_n   = 1'b1;
      out_ready = 1'b0;
      set_rec(32'h4, 1'b0);
      tick();
      chk("pcchk_first", 32'(pc_break), 0);
      set_rec(32'hC, 1'b1);
      tick();
      mfi_valid = 1'b0;
      chk("pcchk_break", 32'(pc_break), EXP_BREAK);
      tick();
      chk("pcchk_sticky", 32'(pc_break), EXP_BREAK);
      chk("pcchk_level", 32'(level), 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
